wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter NREGS, default 32, meaning the register count; AW = clog2(NREGS).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1  (valid/ready accept handshake).
REQ-006 SHALL have ports: in_rd  in  AW; in_regwrite  in  1; in_sel  in  2  (00 ALU, 01 LOAD, 10 LINK, 11 reserved).
REQ-007 SHALL have ports: in_alu_result  in  XLEN; in_pc_plus4  in  XLEN; in_funct3  in  3; in_addr_lo  in  3.
REQ-008 SHALL have ports: mem_rvalid  in  1; mem_rdata  in  XLEN.
REQ-009 SHALL have ports: rf_we  out  1; rf_waddr  out  AW; rf_wdata  out  XLEN.
REQ-010 SHALL have ports: pend_valid  out  1; pend_rd  out  AW  (load in flight, for the hazard unit).
REQ-011 SHALL have ports: load_err  out  1; instret  out  64.

Function
REQ-012 SHALL implement states IDLE, WAIT_MEM and COMMIT.
REQ-013 IDLE: in_ready=1; on accept with in_sel 00, 10 or 11, SHALL capture the instruction and go to COMMIT.
REQ-014 IDLE: on accept with in_sel=01, SHALL capture the instruction and go to WAIT_MEM.
REQ-015 WAIT_MEM: in_ready=0; pend_valid=1; pend_rd=the captured rd.
REQ-016 WAIT_MEM: on mem_rvalid SHALL register the aligned load data and go to COMMIT.
REQ-017 COMMIT lasts exactly one cycle with rf_we = captured regwrite AND (rd != 0).
REQ-018 COMMIT SHALL drive rf_waddr = captured rd.
REQ-019 COMMIT SHALL drive rf_wdata = ALU result, pc_plus4 or aligned load data per in_sel; reserved in_sel writes 0 with rf_we=0.
REQ-020 COMMIT SHALL assert in_ready, allowing back-to-back acceptance: IDLE behaviour applies in the same cycle, and a non-load commits next cycle.
REQ-021 Latency SHALL be: ALU/LINK accept-to-rf_we 1 cycle; LOAD mem_rvalid-to-rf_we 1 cycle.
REQ-022 rf_we, rf_waddr and rf_wdata SHALL be registered outputs; all are 0 outside COMMIT.
REQ-023 Load alignment SHALL support funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, plus 011 LD and 110 LWU when XLEN=64.
REQ-024 Load alignment SHALL select the byte lane by in_addr_lo and sign- or zero-extend to XLEN.
REQ-025 A misaligned access (LH/LHU addr_lo[0]=1; LW/LWU addr_lo[1:0]!=0; LD addr_lo!=0) or an unsupported funct3 SHALL force rf_we=0 and pulse load_err in COMMIT.
REQ-026 mem_rvalid SHALL be ignored in IDLE and COMMIT.
REQ-027 instret SHALL increment by 1 on every COMMIT cycle, including rd=0 and errored commits, and SHALL wrap modulo 2^64.
REQ-028 in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-029 On rst assertion the unit SHALL immediately enter IDLE with rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, load_err=0 and instret=0.
REQ-030 Reset during WAIT_MEM SHALL drop the pending load; a late mem_rvalid after reset SHALL be ignored.

Structure
REQ-031 Package wb_pkg SHALL hold the in_sel encodings, the load funct3 constants and the state enum.
REQ-032 Sub-module load_align SHALL provide the combinational extraction, sign-extension and misalignment check, parametrised by XLEN.

Verification
REQ-033 ALU x5: in_sel=00, rd=5, alu=0x0000_1234, regwrite=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, instret=1.
REQ-034 LB: mem_rdata=0x80FF_7F01, addr_lo=3 -> after mem_rvalid, wdata=0xFFFF_FF80; LBU at addr_lo=3 -> 0x0000_0080.
REQ-035 rd=0 ALU write with alu=0xDEAD_BEEF -> rf_we=0 and instret increments.
REQ-036 LH at addr_lo=1 -> rf_we=0 and load_err pulses for one cycle; back-to-back ALU ops with no idle cycle -> every op commits exactly once.
REQ-037 Load to rd=7, rst asserted while in WAIT_MEM, then mem_rvalid -> no write, pend_valid=0, instret=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back unit: result selects, load funct3 codes, FSM states.
package wb_pkg;

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelLink = 2'b10;
  localparam logic [1:0] SelRsvd = 2'b11;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StCommit
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: byte-lane select, sign/zero extension and misalignment check.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);

  localparam int unsigned LaneW = (XLEN == 64) ? 3 : 2;
  localparam bit          Is64  = (XLEN == 64);

  logic [LaneW-1:0] lane;
  logic [XLEN-1:0]  shifted;

  // On a 32-bit datapath addr_lo[2] does not pick a lane.
  assign lane    = addr_lo[LaneW-1:0];
  assign shifted = rdata >> {lane, 3'b000};

  // Extract and extend per access width; errored accesses return zero.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3Lb:  data = XLEN'($signed(shifted[7:0]));
      F3Lbu: data = XLEN'(shifted[7:0]);
      F3Lh: begin
        err  = addr_lo[0];
        data = XLEN'($signed(shifted[15:0]));
      end
      F3Lhu: begin
        err  = addr_lo[0];
        data = XLEN'(shifted[15:0]);
      end
      F3Lw: begin
        err  = (addr_lo[1:0] != 2'b00);
        data = XLEN'($signed(shifted[31:0]));
      end
      F3Lwu: begin
        err  = !Is64 || (addr_lo[1:0] != 2'b00);
        data = XLEN'(shifted[31:0]);
      end
      F3Ld: begin
        err  = !Is64 || (addr_lo != 3'b000);
        data = shifted;
      end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: accepts one instruction at a time, waits for load data if needed,
// and commits a single registered register-file write.
module wb_unit #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pend_valid,
  output logic [AW-1:0]   pend_rd,
  output logic            load_err,
  output logic [63:0]     instret
);

  import wb_pkg::*;

  wb_state_e state_q, state_d;

  logic [AW-1:0]   rd_q;
  logic            regwrite_q;
  logic [2:0]      funct3_q;
  logic [2:0]      addr_lo_q;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [63:0]     instret_q;

  logic            accept;
  logic [XLEN-1:0] la_data;
  logic            la_err;

  assign accept = in_valid && in_ready;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3 (funct3_q),
    .addr_lo(addr_lo_q),
    .rdata  (mem_rdata),
    .data   (la_data),
    .err    (la_err)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state: COMMIT behaves like IDLE so a new op can be taken every cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StCommit: begin
        if (accept) state_d = (in_sel == SelLoad) ? StWaitMem : StCommit;
        else        state_d = StIdle;
      end
      StWaitMem: if (mem_rvalid) state_d = StCommit;
      default:   state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    in_ready   = (state_q == StIdle) || (state_q == StCommit);
    pend_valid = (state_q == StWaitMem);
    pend_rd    = (state_q == StWaitMem) ? rd_q : '0;
  end

  // Capture the fields a pending load needs once its data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
    end else if (accept) begin
      rd_q       <= in_rd;
      regwrite_q <= in_regwrite;
      funct3_q   <= in_funct3;
      addr_lo_q  <= in_addr_lo;
    end
  end

  // Write values for the coming COMMIT cycle; zero whenever COMMIT is not next.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    err_d   = 1'b0;
    if (accept && (in_sel != SelLoad)) begin
      waddr_d = in_rd;
      case (in_sel)
        SelAlu:  wdata_d = in_alu_result;
        SelLink: wdata_d = in_pc_plus4;
        default: wdata_d = '0;
      endcase
      we_d = in_regwrite && (in_rd != '0) && (in_sel != SelRsvd);
    end else if ((state_q == StWaitMem) && mem_rvalid) begin
      waddr_d = rd_q;
      wdata_d = la_data;
      we_d    = regwrite_q && (rd_q != '0) && !la_err;
      err_d   = la_err;
    end
  end

  // Registered write port and retire counter (counts the commit it is visible with).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (state_d == StCommit) instret_q <= instret_q + 64'd1;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign load_err = err_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit (XLEN=32): directed table, corner sequences, random ops.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_err;
  logic [63:0] instret;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [2:0]  addr;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  wb_unit #(
    .XLEN (32),
    .NREGS(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .in_sel       (in_sel),
    .in_alu_result(in_alu_result),
    .in_pc_plus4  (in_pc_plus4),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pend_valid   (pend_valid),
    .pend_rd      (pend_rd),
    .load_err     (load_err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result of one instruction from the architectural load/write rules.
  function automatic void model(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                                input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [2:0] f3, input logic [2:0] addr,
                                input logic [31:0] rdata, output logic we,
                                output logic [31:0] wd, output logic err);
    int size;
    bit sgn;
    bit ok;
    int lane;
    longint unsigned mask;
    longint unsigned v;
    we = 1'b0; wd = '0; err = 1'b0;
    size = 1; sgn = 1'b0; ok = 1'b1;
    if (sel == 2'd0) begin
      wd = alu; we = rw && (rd != 0);
    end else if (sel == 2'd2) begin
      wd = pc4; we = rw && (rd != 0);
    end else if (sel == 2'd1) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: begin size = 4; sgn = 1'b1; end
        3'd4: begin size = 1; sgn = 1'b0; end
        3'd5: begin size = 2; sgn = 1'b0; end
        default: ok = 1'b0;
      endcase
      lane = int'(addr) % 4;
      if (!ok || (lane % size) != 0) begin
        err = 1'b1;
      end else begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v = (longint'(rdata) >> (8 * lane)) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        wd = v[31:0];
        we = rw && (rd != 0);
      end
    end
  endfunction

  // Issue one op from IDLE, deliver load data after lat cycles, check the commit.
  task automatic run_op(input vec_t v, input int lat, input string tag);
    in_valid = 1'b1; in_sel = v.sel; in_rd = v.rd; in_regwrite = v.rw;
    in_alu_result = v.alu; in_pc_plus4 = v.pc4; in_funct3 = v.f3; in_addr_lo = v.addr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_alu_result = $urandom; in_pc_plus4 = $urandom;
    if (v.sel == 2'd1) begin
      check({tag, " pend_valid"}, 64'(pend_valid), 64'd1);
      check({tag, " pend_rd"}, 64'(pend_rd), 64'(v.rd));
      check({tag, " ready_wait"}, 64'(in_ready), 64'd0);
      repeat (lat) begin
        mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    exp_instret++;
    check({tag, " rf_we"}, 64'(rf_we), 64'(v.exp_we));
    check({tag, " rf_waddr"}, 64'(rf_waddr), 64'(v.rd));
    check({tag, " rf_wdata"}, 64'(rf_wdata), 64'(v.exp_wdata));
    check({tag, " load_err"}, 64'(load_err), 64'(v.exp_err));
    check({tag, " instret"}, instret, exp_instret);
    check({tag, " ready_commit"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check({tag, " we_after"}, 64'(rf_we), 64'd0);
    check({tag, " err_after"}, 64'(load_err), 64'd0);
  endtask

  initial begin
    vec_t rv;
    logic [31:0] b2b_alu[4];

    vecs[0]  = '{2'd0, 5'd5,  1'b1, 32'h0000_1234, 32'h0, 3'd0, 3'd0, 32'h0,
                 1'b1, 32'h0000_1234, 1'b0};
    vecs[1]  = '{2'd1, 5'd6,  1'b1, 32'h0, 32'h0, 3'd0, 3'd3, 32'h80FF_7F01,
                 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{2'd1, 5'd6,  1'b1, 32'h0, 32'h0, 3'd4, 3'd3, 32'h80FF_7F01,
                 1'b1, 32'h0000_0080, 1'b0};
    vecs[3]  = '{2'd0, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'h0, 3'd0, 3'd0, 32'h0,
                 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{2'd1, 5'd9,  1'b1, 32'h0, 32'h0, 3'd1, 3'd1, 32'h80FF_7F01,
                 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{2'd2, 5'd1,  1'b1, 32'h5555, 32'h0000_0100, 3'd0, 3'd0, 32'h0,
                 1'b1, 32'h0000_0100, 1'b0};
    vecs[6]  = '{2'd3, 5'd3,  1'b1, 32'h77, 32'h88, 3'd0, 3'd0, 32'h0,
                 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{2'd1, 5'd10, 1'b1, 32'h0, 32'h0, 3'd2, 3'd0, 32'hCAFE_BABE,
                 1'b1, 32'hCAFE_BABE, 1'b0};
    vecs[8]  = '{2'd1, 5'd11, 1'b1, 32'h0, 32'h0, 3'd5, 3'd2, 32'h80FF_7F01,
                 1'b1, 32'h0000_80FF, 1'b0};
    vecs[9]  = '{2'd1, 5'd12, 1'b1, 32'h0, 32'h0, 3'd1, 3'd2, 32'h80FF_7F01,
                 1'b1, 32'hFFFF_80FF, 1'b0};
    vecs[10] = '{2'd1, 5'd13, 1'b1, 32'h0, 32'h0, 3'd1, 3'd0, 32'h80FF_7F01,
                 1'b1, 32'h0000_7F01, 1'b0};
    vecs[11] = '{2'd1, 5'd14, 1'b1, 32'h0, 32'h0, 3'd3, 3'd0, 32'h1234_5678,
                 1'b0, 32'h0, 1'b1};
    vecs[12] = '{2'd0, 5'd15, 1'b0, 32'h0000_ABCD, 32'h0, 3'd0, 3'd0, 32'h0,
                 1'b0, 32'h0000_ABCD, 1'b0};
    vecs[13] = '{2'd1, 5'd16, 1'b1, 32'h0, 32'h0, 3'd2, 3'd2, 32'h1234_5678,
                 1'b0, 32'h0, 1'b1};
    vecs[14] = '{2'd1, 5'd17, 1'b1, 32'h0, 32'h0, 3'd0, 3'd1, 32'h80FF_7F01,
                 1'b1, 32'h0000_007F, 1'b0};
    vecs[15] = '{2'd1, 5'd0,  1'b1, 32'h0, 32'h0, 3'd2, 3'd0, 32'hFFFF_FFFF,
                 1'b0, 32'hFFFF_FFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_regwrite = 1'b0; in_sel = '0;
    in_alu_result = '0; in_pc_plus4 = '0; in_funct3 = '0; in_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst rf_we", 64'(rf_we), 64'd0);
    check("rst rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst pend_valid", 64'(pend_valid), 64'd0);
    check("rst pend_rd", 64'(pend_rd), 64'd0);
    check("rst load_err", 64'(load_err), 64'd0);
    check("rst instret", instret, 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_op(vecs[i], i % 3, $sformatf("vec%0d", i));

    // Back-to-back ALU ops with in_valid held high.
    for (int i = 0; i < 4; i++) b2b_alu[i] = $urandom;
    in_valid = 1'b1; in_sel = 2'd0; in_regwrite = 1'b1; in_rd = 5'd20; in_alu_result = b2b_alu[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_instret++;
      check($sformatf("b2b%0d rf_we", i), 64'(rf_we), 64'd1);
      check($sformatf("b2b%0d rf_waddr", i), 64'(rf_waddr), 64'(20 + i));
      check($sformatf("b2b%0d rf_wdata", i), 64'(rf_wdata), 64'(b2b_alu[i]));
      check($sformatf("b2b%0d instret", i), instret, exp_instret);
      if (i < 3) begin
        in_rd = 5'(21 + i); in_alu_result = b2b_alu[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("b2b idle rf_we", 64'(rf_we), 64'd0);
    check("b2b idle instret", instret, exp_instret);

    // Load accepted in the COMMIT cycle of a preceding ALU op.
    in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd2; in_alu_result = 32'h0BAD_F00D;
    @(posedge clk); #1;
    exp_instret++;
    check("alu2ld alu wdata", 64'(rf_wdata), 64'h0BAD_F00D);
    in_sel = 2'd1; in_rd = 5'd8; in_funct3 = 3'd2; in_addr_lo = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("alu2ld pend_valid", 64'(pend_valid), 64'd1);
    check("alu2ld we_wait", 64'(rf_we), 64'd0);
    // Requests while not ready must be ignored.
    in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd30; in_alu_result = 32'h1111_1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall pend_valid", 64'(pend_valid), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    exp_instret++;
    check("alu2ld ld waddr", 64'(rf_waddr), 64'd8);
    check("alu2ld ld wdata", 64'(rf_wdata), 64'h1122_3344);
    @(posedge clk); #1;
    check("stall no extra commit", 64'(rf_we), 64'd0);
    check("stall instret", instret, exp_instret);

    // mem_rvalid in IDLE has no effect.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 mem_rvalid = 1'b0;
    check("idle rvalid rf_we", 64'(rf_we), 64'd0);
    check("idle rvalid instret", instret, exp_instret);

    // Random ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      rv.sel = 2'($urandom_range(0, 3));
      rv.rd = 5'($urandom); rv.rw = 1'($urandom);
      rv.alu = $urandom; rv.pc4 = $urandom;
      rv.f3 = 3'($urandom); rv.addr = 3'($urandom); rv.rdata = $urandom;
      model(rv.sel, rv.rd, rv.rw, rv.alu, rv.pc4, rv.f3, rv.addr, rv.rdata,
            rv.exp_we, rv.exp_wdata, rv.exp_err);
      run_op(rv, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    // Reset while a load is pending, then a late mem_rvalid.
    in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd7; in_regwrite = 1'b1;
    in_funct3 = 3'd2; in_addr_lo = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstld pend_rd", 64'(pend_rd), 64'd7);
    rst = 1'b1;
    #1;
    exp_instret = 64'd0;
    check("rstld pend_valid", 64'(pend_valid), 64'd0);
    check("rstld instret", instret, exp_instret);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rstld late rf_we", 64'(rf_we), 64'd0);
    check("rstld late pend_valid", 64'(pend_valid), 64'd0);
    check("rstld late instret", instret, exp_instret);
    @(posedge clk); #1;
    check("rstld after rf_we", 64'(rf_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
